ad_ip_jesd204_tpl_adc_capture: RTL
==================================

Name: ad_ip_jesd204_tpl_adc_capture

Overview:
Downstream of the JESD204 TPL ADC core. Consumes per-channel adc_valid/adc_data and the core's adc_rst_sync (SYSREF-armed) status. Captures a programmed number of beats, optionally gated on sync-arm release, into a small FIFO. Emits the beats as an AXI-Stream burst with TLAST toward the DMA.

Parameters:
NUM_CHANNELS, 1, converter channels in adc_data
DATA_PATH_WIDTH, 1, samples per channel per beat
BITS_PER_SAMPLE, 16, formatted sample width
DMA_DATA_WIDTH, DATA_PATH_WIDTH*BITS_PER_SAMPLE*NUM_CHANNELS, beat width
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH beats
COUNT_WIDTH, 32, capture length counter width

Ports:
clk  in  1  core clock (same as TPL core)
resetn  in  1  asynchronous active-low reset
adc_valid  in  NUM_CHANNELS  from TPL core; only bit 0 is used as beat strobe
adc_data  in  DMA_DATA_WIDTH  formatted data from TPL core
adc_rst_sync  in  1  sync-armed status from TPL core
capture_start  in  1  single-cycle start request
capture_length  in  COUNT_WIDTH  beats to capture; sampled on accepted start
capture_sync_en  in  1  wait for sync-arm release before capturing; sampled on start
capture_abort  in  1  abort and flush, any state
m_axis_valid  out  1  stream valid
m_axis_ready  in  1  stream ready
m_axis_data  out  DMA_DATA_WIDTH  stream data
m_axis_last  out  1  final beat of capture
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
overflow  out  1  sticky FIFO overflow flag
overflow_clr  in  1  clears overflow

Behaviour:
- Reset: state IDLE, FIFO empty, all pointers and counters 0. Outputs busy=0, done=0, overflow=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0.
- FSM states: IDLE, WAIT_SYNC, CAPTURE, DRAIN.
- IDLE: capture_start=1 with capture_length!=0 latches the length into remaining. Next state is WAIT_SYNC if capture_sync_en=1, else CAPTURE. Start with length 0 is ignored. Start while not IDLE is ignored.
- WAIT_SYNC: adc_rst_sync is registered once. Leave to CAPTURE on its 1->0 edge (registered=1, current=0). If adc_rst_sync is already 0 on entry, wait for a full 0->1->0 cycle. The edge cycle's beat is not captured; the first captured beat is the next valid beat.
- CAPTURE: each cycle with adc_valid[0]=1 writes {adc_data, remaining==1} to the FIFO and decrements remaining. When the beat with remaining==1 is written, next state is DRAIN.
- Write acceptance: a write is accepted if the FIFO is not full, or if a read (m_axis_valid & m_axis_ready) occurs in the same cycle.
- Overflow: a valid beat arriving while full with no same-cycle read sets overflow. The FIFO is flushed and the FSM returns to IDLE; done is not asserted.
- DRAIN: no writes. When the last-tagged beat handshakes, next state is IDLE and done=1 for one cycle, in the same cycle IDLE is entered.
- Output: m_axis_valid = FIFO not empty; m_axis_data/m_axis_last come from the FIFO head (registered read). Latency from an accepted beat to m_axis_valid is 1 cycle. Data/last are held stable while valid & !ready.
- capture_abort: takes priority over all events in the same cycle. It flushes the FIFO, clears remaining, forces IDLE, and forces m_axis_valid=0 the next cycle. done is not pulsed; overflow is unchanged.
- overflow_clr vs. set in the same cycle: set wins.
- Counters: remaining is COUNT_WIDTH bits, max capture 2**COUNT_WIDTH-1 beats. FIFO pointers are FIFO_ADDR_WIDTH+1 bits and wrap naturally; full/empty come from the MSB compare.
- Asserting resetn mid-capture discards everything immediately (asynchronous reset).

Optional Feature:
Macro AD_IP_JESD204_TPL_ADC_CAPTURE_TIMESTAMP_EN.
- Defined: adds a 64-bit counter of adc_valid[0] beats since reset, which wraps. Adds output port capture_timestamp (64 bits), which latches the counter value of the first captured beat of each capture. capture_timestamp resets to 0 and holds until the next capture.
- Undefined: no counter and no port; all other behaviour is identical.

Test Plan:
- Basic: length=8, sync_en=0, adc_valid continuous, ready=1 -> 8 beats out in order, last only on beat 8, first m_axis_valid 1 cycle after first write, done pulses once, busy falls the same cycle.
- Sync gating: sync_en=1, adc_rst_sync held 1 for 20 cycles then 0 -> no beats before the fall; first output equals the beat following the fall edge cycle; 4 beats for length=4.
- Backpressure/overflow: FIFO_ADDR_WIDTH=2, ready=0, length=10, continuous valid -> 4 beats stored, 5th sets overflow, FIFO flushed, IDLE, no done; overflow_clr then clears it.
- Full with simultaneous read: FIFO full, ready=1 on the same cycle as a new valid beat -> beat accepted, no overflow, order preserved.
- Abort: abort asserted mid-CAPTURE after 3 beats with ready=0 -> m_axis_valid=0 the next cycle, busy=0, no done; a new start with length=2 then completes normally.
- Edge cases: start with length=0 -> ignored, busy stays 0. Gapped adc_valid (1 of 3 cycles), length=5 -> exactly 5 beats. Timestamp (macro on) equals the beat index of the first captured beat.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_capture_if.sv
// AXI-Stream master/slave bundle for the TPL ADC capture block.
// Carries valid/ready handshake plus beat data and end-of-burst marker.
interface ad_ip_jesd204_tpl_adc_capture_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Captures N beats from the JESD204 TPL ADC core into a FIFO and streams them out.
// Optional beat timestamp: define AD_IP_JESD204_TPL_ADC_CAPTURE_TIMESTAMP_EN.
module ad_ip_jesd204_tpl_adc_capture #(
   parameter int NUM_CHANNELS    = 1,
   parameter int DATA_PATH_WIDTH = 1,
   parameter int BITS_PER_SAMPLE = 16,
   parameter int DMA_DATA_WIDTH  = DATA_PATH_WIDTH*BITS_PER_SAMPLE*NUM_CHANNELS,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int COUNT_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_CHANNELS-1:0]   adc_valid,
   input  logic [DMA_DATA_WIDTH-1:0] adc_data,
   input  logic                      adc_rst_sync,
   input  logic                      capture_start,
   input  logic [COUNT_WIDTH-1:0]    capture_length,
   input  logic                      capture_sync_en,
   input  logic                      capture_abort,
   ad_ip_jesd204_tpl_adc_capture_if.master m_axis,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
`ifdef AD_IP_JESD204_TPL_ADC_CAPTURE_TIMESTAMP_EN
   output logic [63:0]               capture_timestamp,
`endif
   input  logic                      overflow_clr
);

   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int PW    = FIFO_ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE, WAIT_SYNC, CAPTURE, DRAIN
   } state_t;

   state_t                  state_q, state_d;
   logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [DMA_DATA_WIDTH:0] mem_q [DEPTH];
   logic                    sync_q;
   logic                    done_q, done_d;
   logic                    ovf_q;

   logic                    empty, full, rd_fire, wr_ok;
   logic                    wr_en, flush, ovf_set, start_ok;
   logic [DMA_DATA_WIDTH:0] head;

   assign empty   = wr_ptr_q == rd_ptr_q;
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_fire = !empty && m_axis.ready;
   assign wr_ok   = !full || rd_fire;

   assign m_axis.valid = !empty;
   assign m_axis.data  = empty ? '0 : head[DMA_DATA_WIDTH-1:0];
   assign m_axis.last  = !empty && head[DMA_DATA_WIDTH];

   assign busy     = state_q != IDLE;
   assign done     = done_q;
   assign overflow = ovf_q;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      wr_en    = 1'b0;
      flush    = 1'b0;
      ovf_set  = 1'b0;
      done_d   = 1'b0;
      start_ok = 1'b0;
      // Abort outranks every other event this cycle
      if (capture_abort) begin
         state_d = IDLE;
         rem_d   = '0;
         flush   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (capture_start && capture_length != '0) begin
                  start_ok = 1'b1;
                  rem_d    = capture_length;
                  state_d  = capture_sync_en ? WAIT_SYNC : CAPTURE;
               end
            end
            WAIT_SYNC: begin
               if (sync_q && !adc_rst_sync) state_d = CAPTURE;
            end
            CAPTURE: begin
               if (adc_valid[0]) begin
                  if (wr_ok) begin
                     wr_en = 1'b1;
                     rem_d = rem_q - COUNT_WIDTH'(1);
                     if (rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
                  end else begin
                     ovf_set = 1'b1;
                     flush   = 1'b1;
                     rem_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
            DRAIN: begin
               if (rd_fire && head[DMA_DATA_WIDTH]) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sync_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sync_q  <= adc_rst_sync;
         done_q  <= done_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_en)   wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (ovf_set)           ovf_q <= 1'b1;
         else if (overflow_clr) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {rem_q == COUNT_WIDTH'(1), adc_data};
   end

`ifdef AD_IP_JESD204_TPL_ADC_CAPTURE_TIMESTAMP_EN
   logic [63:0] beat_cnt_q, ts_q;
   logic        first_q;

   assign capture_timestamp = ts_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt_q <= '0;
         ts_q       <= '0;
         first_q    <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_q + 64'(adc_valid[0]);
         if (start_ok) begin
            first_q <= 1'b1;
         end else if (wr_en && first_q) begin
            first_q <= 1'b0;
            ts_q    <= beat_cnt_q;
         end
      end
   end
`endif

endmodule
